op_decoder: RTL and testbench

//  Registered 3-to-8 opcode decoder, the inverse of the function-code encoder.
//  It accepts a binary op_code over a valid/ready handshake and emits the one-hot

---
 rtl/op_decoder_pkg.sv | 24 ++
 rtl/op_decoder_if.sv | 35 +++
 rtl/op_decoder_skid_buf.sv | 83 ++++++++
 rtl/op_decoder.sv | 73 +++++++
 tb/tb_op_decoder.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/op_decoder_pkg.sv
// -----------------------------------------------------------------------------
// op_decoder_pkg
//   Shared types and constants for the opcode decoder. This package holds the
//   opcode/one-hot widths and their types. It also provides op2fn(), the
//   canonical binary-to-one-hot mapping, and the default enable mask and
//   counter width.
// -----------------------------------------------------------------------------
package op_decoder_pkg;

    localparam int OP_W  = 3;
    localparam int FN_W  = 8;            // must equal 2**OP_W
    localparam int CNT_W = 8;

    typedef logic [OP_W-1:0] op_t;
    typedef logic [FN_W-1:0] fn_onehot_t;

    // Every opcode legal unless the instance narrows the mask.
    localparam fn_onehot_t EN_MASK_DEFAULT = 8'hFF;

    function automatic fn_onehot_t op2fn(op_t op);
        return fn_onehot_t'(1) << op;
    endfunction

endpackage

// File: rtl/op_decoder_if.sv
// -----------------------------------------------------------------------------
// op_decoder_if
//   Bundles the opcode decoder's upstream (op_code valid/ready) and downstream
//   (function_code valid/ready) handshakes plus its error reporting.
//   master : the environment side (sequencer + function units)
//   slave  : the decoder side
// -----------------------------------------------------------------------------
interface op_decoder_if
    import op_decoder_pkg::*;
#(
    parameter int OP_W_P  = OP_W,
    parameter int FN_W_P  = FN_W,
    parameter int CNT_W_P = CNT_W
) ();

    logic               in_valid;
    logic               in_ready;
    logic [OP_W_P-1:0]  op_code;
    logic               out_valid;
    logic               out_ready;
    logic [FN_W_P-1:0]  function_code;
    logic               err;
    logic [CNT_W_P-1:0] err_count;

    modport master (
        output in_valid, op_code, out_ready,
        input  in_ready, out_valid, function_code, err, err_count
    );

    modport slave (
        input  in_valid, op_code, out_ready,
        output in_ready, out_valid, function_code, err, err_count
    );

endinterface

// File: rtl/op_decoder_skid_buf.sv
// -----------------------------------------------------------------------------
// fn_skid_buf
//   Two-entry, width-parameterised valid/ready FIFO used as a skid buffer.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     push_i        producer offers data_i (taken only while ready_o)
//     data_i        entry to enqueue
//     ready_o       registered "not full"; no combinational path from pop_i
//     valid_o       buffer holds at least one entry
//     pop_i         consumer ready; pops the head when valid_o
//     data_o        head entry, forced to 0 when empty
// -----------------------------------------------------------------------------
module fn_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    output logic         ready_o,
    output logic         valid_o,
    input  logic         pop_i,
    output logic [W-1:0] data_o
);

    logic [1:0]   count_q, count_d;
    logic [W-1:0] slot0_q, slot0_d;    // head
    logic [W-1:0] slot1_q, slot1_d;    // tail when count==2
    logic         ready_q;

    logic push, pop;

    assign push = push_i && ready_q;
    assign pop  = (count_q != 2'd0) && pop_i;

    always_comb begin
        count_d = count_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) slot0_d = data_i;
                else                 slot1_d = data_i;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Count stays put; the new entry lands behind whatever remains.
                if (count_q == 2'd1) begin
                    slot0_d = data_i;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            slot0_q <= '0;
            slot1_q <= '0;
            ready_q <= 1'b1;
        end else begin
            count_q <= count_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            // Registered from next-state count, so a pop frees the slot one
            // cycle later and out_ready never reaches ready_o combinationally.
            ready_q <= (count_d != 2'd2);
        end
    end

    assign ready_o = ready_q;
    assign valid_o = (count_q != 2'd0);
    assign data_o  = valid_o ? slot0_q : '0;

endmodule

// File: rtl/op_decoder.sv
// -----------------------------------------------------------------------------
// op_decoder
//   Registered 3-to-8 opcode decoder. Accepts binary op_codes over a
//   valid/ready handshake. Each one is decoded to a one-hot function_code and
//   queued in a 2-entry skid buffer. Opcodes masked off by EN_MASK are consumed
//   but never enqueued; each one raises a 1-cycle err pulse and bumps a
//   saturating counter.
//   Ports:
//     clk   clock
//     rst   synchronous active-high reset
//     bus   op_decoder_if.slave: in_valid/in_ready/op_code,
//           out_valid/out_ready/function_code, err, err_count
// -----------------------------------------------------------------------------
module op_decoder
    import op_decoder_pkg::*;
#(
    parameter int              OP_W_P  = OP_W,
    parameter int              FN_W_P  = FN_W,     // must equal 2**OP_W_P
    parameter logic [FN_W_P-1:0] EN_MASK = EN_MASK_DEFAULT,
    parameter int              CNT_W_P = CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    op_decoder_if.slave bus
);

    logic              accept;
    logic              legal;
    logic              push;
    logic [FN_W_P-1:0] fn_dec;
    logic              buf_ready;

    logic               err_q, err_d;
    logic [CNT_W_P-1:0] err_count_q, err_count_d;

    assign accept = bus.in_valid && buf_ready;
    assign legal  = EN_MASK[bus.op_code];
    assign push   = accept && legal;
    assign fn_dec = FN_W_P'(1) << bus.op_code;

    fn_skid_buf #(.W(FN_W_P)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (fn_dec),
        .ready_o (buf_ready),
        .valid_o (bus.out_valid),
        .pop_i   (bus.out_ready),
        .data_o  (bus.function_code)
    );

    always_comb begin
        err_d       = accept && !legal;
        err_count_d = err_count_q;
        if (err_d && (err_count_q != '1))
            err_count_d = err_count_q + CNT_W_P'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.in_ready  = buf_ready;
    assign bus.err       = err_q;
    assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_op_decoder.sv
// -----------------------------------------------------------------------------
// tb_op_decoder
//   Directed bench for op_decoder. dut_a uses the full enable mask and dut_m
//   uses 8'hEF, which disables op 4. Inputs change on the falling edge and
//   outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_op_decoder;
    import op_decoder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    op_decoder_if bus_a ();
    op_decoder_if bus_m ();

    op_decoder #(.EN_MASK(8'hFF)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    op_decoder #(.EN_MASK(8'hEF)) dut_m (.clk(clk), .rst(rst), .bus(bus_m));

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0] op;
        logic [7:0] exp_fn;
    } vec_t;

    vec_t sweep [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        if (!rst && bus_a.in_valid && bus_a.in_ready)
            assert (!$isunknown(bus_a.op_code)) else $error("X op_code on accept (a)");
        if (!rst && bus_m.in_valid && bus_m.in_ready)
            assert (!$isunknown(bus_m.op_code)) else $error("X op_code on accept (m)");
    end

    initial begin
        sweep[0] = '{3'd0, 8'h01};
        sweep[1] = '{3'd1, 8'h02};
        sweep[2] = '{3'd2, 8'h04};
        sweep[3] = '{3'd3, 8'h08};
        sweep[4] = '{3'd4, 8'h10};
        sweep[5] = '{3'd5, 8'h20};
        sweep[6] = '{3'd6, 8'h40};
        sweep[7] = '{3'd7, 8'h80};

        bus_a.in_valid = 1'b0; bus_a.op_code = '0; bus_a.out_ready = 1'b0;
        bus_m.in_valid = 1'b0; bus_m.op_code = '0; bus_m.out_ready = 1'b1;

        // ---- 1: reset held 3 cycles
        @(negedge clk);
        repeat (3) step();
        chk("rst out_valid", 32'(bus_a.out_valid), 32'd0);
        chk("rst fn",        32'(bus_a.function_code), 32'd0);
        chk("rst in_ready",  32'(bus_a.in_ready), 32'd1);
        chk("rst err_count", 32'(bus_a.err_count), 32'd0);
        chk("rst err",       32'(bus_a.err), 32'd0);
        rst = 1'b0;
        step();

        // ---- 2: back-to-back sweep, one-cycle latency
        bus_a.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus_a.in_valid = 1'b1;
            bus_a.op_code  = sweep[i].op;
            step();
            chk($sformatf("sweep fn op%0d", i), 32'(bus_a.function_code), 32'(sweep[i].exp_fn));
            chk($sformatf("sweep vld op%0d", i), 32'(bus_a.out_valid), 32'd1);
        end
        bus_a.in_valid = 1'b0;
        step();
        chk("sweep drain out_valid", 32'(bus_a.out_valid), 32'd0);
        chk("sweep drain fn",        32'(bus_a.function_code), 32'd0);

        // ---- 3: backpressure, op 3,5 fill the buffer, op 6 waits
        bus_a.out_ready = 1'b0;
        bus_a.in_valid = 1'b1; bus_a.op_code = 3'd3;
        step();
        chk("bp head 08", 32'(bus_a.function_code), 32'h08);
        bus_a.op_code = 3'd5;
        step();
        chk("bp full in_ready", 32'(bus_a.in_ready), 32'd0);
        bus_a.op_code = 3'd6;
        step();
        chk("bp still full", 32'(bus_a.in_ready), 32'd0);
        chk("bp head held",  32'(bus_a.function_code), 32'h08);
        bus_a.out_ready = 1'b1;
        step();
        chk("bp out 20",      32'(bus_a.function_code), 32'h20);
        chk("bp slot freed",  32'(bus_a.in_ready), 32'd1);
        step();
        chk("bp out 40", 32'(bus_a.function_code), 32'h40);
        bus_a.in_valid = 1'b0;
        step();
        chk("bp drained", 32'(bus_a.out_valid), 32'd0);

        // ---- 4: masked opcode on dut_m
        bus_m.in_valid = 1'b1; bus_m.op_code = 3'd4;
        step();
        chk("mask no out_valid", 32'(bus_m.out_valid), 32'd0);
        chk("mask err pulse",    32'(bus_m.err), 32'd1);
        chk("mask err_count 1",  32'(bus_m.err_count), 32'd1);
        bus_m.in_valid = 1'b0;
        step();
        chk("mask err cleared", 32'(bus_m.err), 32'd0);
        bus_m.in_valid = 1'b1; bus_m.op_code = 3'd3;
        step();
        chk("mask legal fn",  32'(bus_m.function_code), 32'h08);
        chk("mask legal err", 32'(bus_m.err), 32'd0);
        bus_m.op_code = 3'd4;
        repeat (300) step();
        chk("mask saturate", 32'(bus_m.err_count), 32'd255);
        chk("mask still rdy", 32'(bus_m.in_ready), 32'd1);
        bus_m.in_valid = 1'b0;
        step();
        chk("mask sat hold", 32'(bus_m.err_count), 32'd255);

        // ---- 5: push+pop at count==1
        bus_a.in_valid = 1'b1; bus_a.op_code = 3'd2;
        step();
        chk("pp first 04",  32'(bus_a.function_code), 32'h04);
        bus_a.op_code = 3'd7;
        step();
        chk("pp valid held", 32'(bus_a.out_valid), 32'd1);
        chk("pp second 80",  32'(bus_a.function_code), 32'h80);
        bus_a.in_valid = 1'b0;
        step();
        chk("pp drained", 32'(bus_a.out_valid), 32'd0);

        // ---- 6: reset with two entries buffered
        bus_a.out_ready = 1'b0;
        bus_a.in_valid = 1'b1; bus_a.op_code = 3'd1;
        step();
        bus_a.op_code = 3'd2;
        step();
        chk("mid full", 32'(bus_a.in_ready), 32'd0);
        bus_a.in_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("mid rst out_valid", 32'(bus_a.out_valid), 32'd0);
        chk("mid rst in_ready",  32'(bus_a.in_ready), 32'd1);
        chk("mid rst fn",        32'(bus_a.function_code), 32'd0);
        rst = 1'b0;
        bus_a.out_ready = 1'b1;
        repeat (2) begin
            step();
            chk("mid no stale", 32'(bus_a.out_valid), 32'd0);
        end
        bus_a.in_valid = 1'b1; bus_a.op_code = 3'd1;
        step();
        chk("mid resume fn", 32'(bus_a.function_code), 32'(op2fn(3'd1)));
        bus_a.in_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
